// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 868;

    function automatic logic uart_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clocks within one serial bit and flags the last one.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_last
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] bit_cnt;

    assign bit_last = bit_cnt == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bit_cnt <= '0;
        else if (clr || (en && bit_last))
            bit_cnt <= '0;
        else if (en)
            bit_cnt <= bit_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains a show-ahead FIFO onto a UART tx line.
// Define UART_TX_PARITY_EN to append an even parity bit before the stop bit.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy
);

    localparam int IW = $clog2(DATA_BITS) + 1;

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [IW-1:0]        idx;
    logic                 bit_last;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    // Popping straight out of STOP keeps back-to-back frames gapless.
    assign fifo_rd_en = !rst && !fifo_empty && (state == IDLE || (state == STOP && bit_last));

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .en       (1'b1),
        .bit_last (bit_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            shift <= '0;
            idx   <= '0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (fifo_rd_en) begin
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            shift <= fifo_dout;
            idx   <= '0;
`ifdef UART_TX_PARITY_EN
            par   <= uart_parity(32'(fifo_dout));
`endif
        end else if (bit_last) begin
            case (state)
                START: begin
                    state <= DATA;
                    tx    <= shift[0];
                end
                DATA: begin
                    if (idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        shift <= shift >> 1;
                        idx   <= idx + 1'b1;
                        tx    <= shift[1];
                    end
                end
                PARITY: begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
                STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
